// File: rtl/maze_game_ctrl_pkg.sv
// Shared types and constants for the maze game sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package maze_game_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PLAY  = 3'd2,
      ST_CHECK = 3'd3,
      ST_WIN   = 3'd4
   } state_t;

   localparam logic [1:0] LVL_NONE = 2'b00;
   localparam logic [1:0] LVL_EASY = 2'b01;
   localparam logic [1:0] LVL_MED  = 2'b10;
   localparam logic [1:0] LVL_HARD = 2'b11;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b1000;
   localparam logic [3:0] DIR_DOWN  = 4'b0100;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0001;

   // Playable width in blocks; an unlatched level allows no moves at all.
   function automatic logic [5:0] grid_w(input logic [1:0] lvl);
      case (lvl)
         LVL_EASY: grid_w = 6'd16;
         LVL_MED:  grid_w = 6'd32;
         LVL_HARD: grid_w = 6'd40;
         default:  grid_w = 6'd0;
      endcase
   endfunction

   // Playable height in blocks.
   function automatic logic [4:0] grid_h(input logic [1:0] lvl);
      case (lvl)
         LVL_EASY: grid_h = 5'd12;
         LVL_MED:  grid_h = 5'd24;
         LVL_HARD: grid_h = 5'd30;
         default:  grid_h = 5'd0;
      endcase
   endfunction

   // Collapse simultaneous button edges to one direction: up > down > left > right.
   function automatic logic [3:0] dir_prio(input logic [3:0] edges);
      if (edges[3])      dir_prio = DIR_UP;
      else if (edges[2]) dir_prio = DIR_DOWN;
      else if (edges[1]) dir_prio = DIR_LEFT;
      else if (edges[0]) dir_prio = DIR_RIGHT;
      else               dir_prio = DIR_NONE;
   endfunction

endpackage

// File: rtl/maze_game_ctrl_move_check.sv
// Combinational move legality check: bounds, wall lookup and goal hit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module maze_move_check import maze_game_ctrl_pkg::*; #(
   parameter int MAP_W    = 40,
   parameter int MAP_BITS = 1200
) (
   input  logic [5:0]          pos_x,
   input  logic [4:0]          pos_y,
   input  logic [3:0]          dir,
   input  logic [1:0]          level,
   input  logic [MAP_BITS-1:0] map,
   input  logic [5:0]          goal_x,
   input  logic [4:0]          goal_y,
   output logic [5:0]          tgt_x,
   output logic [4:0]          tgt_y,
   output logic                accept,
   output logic                goal_hit
);

   logic [6:0]  tx;
   logic [5:0]  ty;
   logic        under;
   logic        in_bounds;
   logic [10:0] idx;
   logic [10:0] bit_idx;
   logic        wall;

   // One spare bit on each target coordinate so a +1 step never wraps before the bound test.
   always_comb begin
      tx    = {1'b0, pos_x};
      ty    = {1'b0, pos_y};
      under = 1'b0;
      case (dir)
         DIR_UP:    if (pos_y == 5'd0) under = 1'b1; else ty = ty - 6'd1;
         DIR_DOWN:  ty = ty + 6'd1;
         DIR_LEFT:  if (pos_x == 6'd0) under = 1'b1; else tx = tx - 7'd1;
         DIR_RIGHT: tx = tx + 7'd1;
         default:   under = 1'b1;
      endcase
      in_bounds = !under && (tx < {1'b0, grid_w(level)}) && (ty < {1'b0, grid_h(level)});
      idx       = 11'(ty) * 11'(MAP_W) + 11'(tx);
      // Only index the map when in bounds, so the bit select stays inside 0..MAP_BITS-1.
      bit_idx   = in_bounds ? (11'(MAP_BITS - 1) - idx) : 11'd0;
      wall      = in_bounds ? map[bit_idx] : 1'b0;
      accept    = in_bounds && !wall;
      tgt_x     = tx[5:0];
      tgt_y     = ty[4:0];
      goal_hit  = accept && (tgt_x == goal_x) && (tgt_y == goal_y);
   end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: latches level/positions, queues one move, commits it on a frame boundary.
// Latency: a press commits 2 cycles after the first draw-done edge following it.
// Backpressure: one pending move; further presses are dropped until it is resolved.
module maze_game_ctrl import maze_game_ctrl_pkg::*; #(
   parameter int MAP_W    = 40,
   parameter int MAP_BITS = 1200,
   parameter int MOVE_MAX = 999
) (
   input  logic                i_Clk,
   input  logic                i_Rst,
   input  logic [1:0]          i_Level,
   input  logic                i_Start,
   input  logic [3:0]          i_Btn,
   input  logic [MAP_BITS-1:0] i_Map,
   input  logic [5:0]          i_StartPos_X,
   input  logic [4:0]          i_StartPos_Y,
   input  logic [5:0]          i_GoalX,
   input  logic [4:0]          i_GoalY,
   input  logic                i_fDrawDone,
   output logic [1:0]          o_Level,
   output logic [5:0]          o_PlayerPos_X,
   output logic [4:0]          o_PlayerPos_Y,
   output logic [5:0]          o_GoalPos_X,
   output logic [4:0]          o_GoalPos_Y,
   output logic [2:0]          o_State,
   output logic                o_Win,
   output logic [9:0]          o_MoveCnt
);

   state_t     state_q, state_n;
   logic [1:0] level_q, level_n;
   logic [5:0] px_q, px_n, gx_q, gx_n;
   logic [4:0] py_q, py_n, gy_q, gy_n;
   logic [9:0] cnt_q, cnt_n;
   logic [3:0] pend_q, pend_n;
   logic       start_d, done_d;
   logic [3:0] btn_d;

   logic       start_edge, done_edge;
   logic [3:0] btn_edge;
   logic [5:0] tgt_x;
   logic [4:0] tgt_y;
   logic       accept, goal_hit;

   assign start_edge = i_Start & ~start_d;
   assign done_edge  = i_fDrawDone & ~done_d;
   assign btn_edge   = i_Btn & ~btn_d;

   maze_move_check #(
      .MAP_W    (MAP_W),
      .MAP_BITS (MAP_BITS)
   ) u_move_check (
      .pos_x    (px_q),
      .pos_y    (py_q),
      .dir      (pend_q),
      .level    (level_q),
      .map      (i_Map),
      .goal_x   (gx_q),
      .goal_y   (gy_q),
      .tgt_x    (tgt_x),
      .tgt_y    (tgt_y),
      .accept   (accept),
      .goal_hit (goal_hit)
   );

   // Next-state and next-register values; everything holds unless a state says otherwise.
   always_comb begin
      state_n = state_q;
      level_n = level_q;
      px_n    = px_q;
      py_n    = py_q;
      gx_n    = gx_q;
      gy_n    = gy_q;
      cnt_n   = cnt_q;
      pend_n  = pend_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge && (i_Level != LVL_NONE)) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            level_n = i_Level;
            px_n    = i_StartPos_X;
            py_n    = i_StartPos_Y;
            gx_n    = i_GoalX;
            gy_n    = i_GoalY;
            cnt_n   = 10'd0;
            pend_n  = DIR_NONE;
            state_n = ST_PLAY;
         end
         ST_PLAY: begin
            // Restart beats a pending move; LOAD clears the pending register.
            if (start_edge)                                state_n = ST_LOAD;
            else if ((pend_q != DIR_NONE) && done_edge)    state_n = ST_CHECK;
            else if ((pend_q == DIR_NONE) && (btn_edge != 4'd0)) pend_n = dir_prio(btn_edge);
         end
         ST_CHECK: begin
            pend_n  = DIR_NONE;
            state_n = goal_hit ? ST_WIN : ST_PLAY;
            if (accept) begin
               px_n  = tgt_x;
               py_n  = tgt_y;
               cnt_n = (cnt_q >= 10'(MOVE_MAX)) ? cnt_q : cnt_q + 10'd1;
            end
         end
         ST_WIN: begin
            if (start_edge) state_n = (i_Level != LVL_NONE) ? ST_LOAD : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State, game registers and input edge history.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q <= ST_IDLE;
         level_q <= LVL_NONE;
         px_q    <= '0;
         py_q    <= '0;
         gx_q    <= '0;
         gy_q    <= '0;
         cnt_q   <= '0;
         pend_q  <= DIR_NONE;
         start_d <= 1'b0;
         done_d  <= 1'b0;
         btn_d   <= '0;
      end else begin
         state_q <= state_n;
         level_q <= level_n;
         px_q    <= px_n;
         py_q    <= py_n;
         gx_q    <= gx_n;
         gy_q    <= gy_n;
         cnt_q   <= cnt_n;
         pend_q  <= pend_n;
         start_d <= i_Start;
         done_d  <= i_fDrawDone;
         btn_d   <= i_Btn;
      end
   end

   assign o_State       = state_q;
   assign o_Level       = level_q;
   assign o_PlayerPos_X = px_q;
   assign o_PlayerPos_Y = py_q;
   assign o_GoalPos_X   = gx_q;
   assign o_GoalPos_Y   = gy_q;
   assign o_MoveCnt     = cnt_q;
   assign o_Win         = (state_q == ST_WIN);

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl: stimulus pushes expected snapshots, monitor compares.
// Latency: monitor checks each snapshot at the following falling edge.
// Backpressure: n/a.
module tb_maze_game_ctrl;

   localparam logic [3:0] U = 4'b1000, D = 4'b0100, L = 4'b0010, R = 4'b0001;

   logic          i_Clk = 1'b0;
   logic          i_Rst;
   logic [1:0]    i_Level;
   logic          i_Start;
   logic [3:0]    i_Btn;
   logic [1199:0] i_Map;
   logic [5:0]    i_StartPos_X, i_GoalX;
   logic [4:0]    i_StartPos_Y, i_GoalY;
   logic          i_fDrawDone;
   logic [1:0]    o_Level;
   logic [5:0]    o_PlayerPos_X, o_GoalPos_X;
   logic [4:0]    o_PlayerPos_Y, o_GoalPos_Y;
   logic [2:0]    o_State;
   logic          o_Win;
   logic [9:0]    o_MoveCnt;

   maze_game_ctrl dut (
      .i_Clk        (i_Clk),
      .i_Rst        (i_Rst),
      .i_Level      (i_Level),
      .i_Start      (i_Start),
      .i_Btn        (i_Btn),
      .i_Map        (i_Map),
      .i_StartPos_X (i_StartPos_X),
      .i_StartPos_Y (i_StartPos_Y),
      .i_GoalX      (i_GoalX),
      .i_GoalY      (i_GoalY),
      .i_fDrawDone  (i_fDrawDone),
      .o_Level      (o_Level),
      .o_PlayerPos_X(o_PlayerPos_X),
      .o_PlayerPos_Y(o_PlayerPos_Y),
      .o_GoalPos_X  (o_GoalPos_X),
      .o_GoalPos_Y  (o_GoalPos_Y),
      .o_State      (o_State),
      .o_Win        (o_Win),
      .o_MoveCnt    (o_MoveCnt)
   );

   always #5 i_Clk = ~i_Clk;

   typedef struct {
      string       name;
      logic [31:0] st, lvl, x, y, gx, gy, cnt, win;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %0d, expected %0d", nm, fld, act, exp);
      end
   endtask

   // Monitor: pop one expected snapshot per falling edge and compare every output.
   always @(negedge i_Clk) begin
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         cmp(mon_e.name, "state", 32'(o_State),       mon_e.st);
         cmp(mon_e.name, "level", 32'(o_Level),       mon_e.lvl);
         cmp(mon_e.name, "x",     32'(o_PlayerPos_X), mon_e.x);
         cmp(mon_e.name, "y",     32'(o_PlayerPos_Y), mon_e.y);
         cmp(mon_e.name, "gx",    32'(o_GoalPos_X),   mon_e.gx);
         cmp(mon_e.name, "gy",    32'(o_GoalPos_Y),   mon_e.gy);
         cmp(mon_e.name, "cnt",   32'(o_MoveCnt),     mon_e.cnt);
         cmp(mon_e.name, "win",   32'(o_Win),         mon_e.win);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge i_Clk);
      #1;
   endtask

   task automatic expect_out(input string nm, input int st, lvl, x, y, gx, gy, cnt, win);
      exp_t e;
      e.name = nm;
      e.st = st; e.lvl = lvl; e.x = x; e.y = y;
      e.gx = gx; e.gy = gy; e.cnt = cnt; e.win = win;
      sb.push_back(e);
      tick(1);
   endtask

   task automatic set_pos(input int sx, sy, gx, gy);
      i_StartPos_X = 6'(sx);
      i_StartPos_Y = 5'(sy);
      i_GoalX      = 6'(gx);
      i_GoalY      = 5'(gy);
   endtask

   task automatic press(input logic [3:0] b);
      i_Btn = b;
      tick(1);
      i_Btn = 4'd0;
      tick(1);
   endtask

   task automatic frame();
      i_fDrawDone = 1'b1;
      tick(2);
      i_fDrawDone = 1'b0;
      tick(1);
   endtask

   task automatic start(input logic [1:0] lvl);
      i_Level = lvl;
      i_Start = 1'b1;
      tick(2);
      i_Start = 1'b0;
      tick(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      i_Rst = 1'b0; i_Level = 2'b00; i_Start = 1'b0; i_Btn = 4'hF;
      i_Map = '0; i_fDrawDone = 1'b0;
      set_pos(0, 0, 0, 0);
      tick(2);
      expect_out("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      i_Rst = 1'b1;
      tick(3);
      i_Btn = 4'd0;
      tick(3);
      expect_out("post_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0);

      set_pos(2, 3, 5, 3);
      start(2'b00);
      expect_out("start_lvl00", 0, 0, 0, 0, 0, 0, 0, 0);

      start(2'b01);
      expect_out("load_easy", 2, 1, 2, 3, 5, 3, 0, 0);
      press(R); frame();
      expect_out("right1", 2, 1, 3, 3, 5, 3, 1, 0);
      press(R); frame();
      expect_out("right2", 2, 1, 4, 3, 5, 3, 2, 0);
      press(R); frame();
      expect_out("reach_goal", 4, 1, 5, 3, 5, 3, 3, 1);
      press(L); frame();
      expect_out("win_frozen", 4, 1, 5, 3, 5, 3, 3, 1);

      i_Map[1199-123] = 1'b1;
      start(2'b01);
      expect_out("reload", 2, 1, 2, 3, 5, 3, 0, 0);
      press(R); frame();
      expect_out("wall_block", 2, 1, 2, 3, 5, 3, 0, 0);
      i_Map = '0;

      set_pos(15, 11, 39, 29);
      start(2'b01);
      expect_out("load_corner", 2, 1, 15, 11, 39, 29, 0, 0);
      press(R); frame();
      expect_out("easy_right_edge", 2, 1, 15, 11, 39, 29, 0, 0);
      press(D); frame();
      expect_out("easy_bottom_edge", 2, 1, 15, 11, 39, 29, 0, 0);
      start(2'b11);
      expect_out("load_hard", 2, 3, 15, 11, 39, 29, 0, 0);
      press(R); frame();
      expect_out("hard_right", 2, 3, 16, 11, 39, 29, 1, 0);
      press(D); frame();
      expect_out("hard_down", 2, 3, 16, 12, 39, 29, 2, 0);

      set_pos(0, 0, 39, 29);
      start(2'b01);
      expect_out("load_origin", 2, 1, 0, 0, 39, 29, 0, 0);
      press(U); frame();
      expect_out("up_underflow", 2, 1, 0, 0, 39, 29, 0, 0);
      press(L); frame();
      expect_out("left_underflow", 2, 1, 0, 0, 39, 29, 0, 0);

      set_pos(4, 4, 10, 10);
      start(2'b01);
      i_Btn = U | L;
      tick(1);
      i_Btn = 4'd0;
      tick(1);
      frame();
      expect_out("prio_up_left", 2, 1, 4, 3, 10, 10, 1, 0);
      press(D); press(L); frame();
      expect_out("drop_second", 2, 1, 4, 4, 10, 10, 2, 0);
      frame();
      expect_out("frame_no_pending", 2, 1, 4, 4, 10, 10, 2, 0);
      i_Btn = R;
      tick(10);
      frame();
      expect_out("held_first", 2, 1, 5, 4, 10, 10, 3, 0);
      tick(40);
      frame();
      expect_out("held_once", 2, 1, 5, 4, 10, 10, 3, 0);
      tick(40);
      i_Btn = 4'd0;
      tick(1);

      press(U);
      start(2'b01);
      expect_out("restart_pending", 2, 1, 4, 4, 10, 10, 0, 0);
      frame();
      expect_out("pending_discarded", 2, 1, 4, 4, 10, 10, 0, 0);

      set_pos(4, 4, 5, 4);
      start(2'b01);
      press(R); frame();
      expect_out("win_one_move", 4, 1, 5, 4, 5, 4, 1, 1);
      start(2'b00);
      expect_out("win_to_idle", 0, 1, 5, 4, 5, 4, 1, 0);

      set_pos(10, 10, 39, 29);
      start(2'b11);
      for (int i = 0; i < 999; i++) begin
         press((i % 2 == 0) ? R : L);
         frame();
      end
      expect_out("cnt_999", 2, 3, 11, 10, 39, 29, 999, 0);
      press(L); frame();
      expect_out("cnt_saturate", 2, 3, 10, 10, 39, 29, 999, 0);

      press(R);
      i_fDrawDone = 1'b1;
      tick(1);
      sb.push_back('{name: "in_check", st: 3, lvl: 3, x: 10, y: 10, gx: 39, gy: 29, cnt: 999, win: 0});
      @(negedge i_Clk);
      #1;
      i_Rst = 1'b0;
      #1;
      sb.push_back('{name: "reset_mid_check", st: 0, lvl: 0, x: 0, y: 0, gx: 0, gy: 0, cnt: 0, win: 0});
      tick(1);
      i_fDrawDone = 1'b0;
      i_Rst = 1'b1;
      tick(2);
      expect_out("after_mid_reset", 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge i_Clk);
      #1;
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d snapshots left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
